// File: rtl/rcs_subtractor_full_subtractor.sv
// -----------------------------------------------------------------------------
// full_subtractor
//   One-bit full-subtractor cell used as the building block of the
//   ripple-borrow chain in rcs_subtractor.
//
//   Ports
//     a       in   minuend bit
//     b       in   subtrahend bit
//     br_in   in   borrow from the next less-significant cell
//     d       out  difference bit
//     br_out  out  borrow into the next more-significant cell
// -----------------------------------------------------------------------------
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic br_in,
    output logic d,
    output logic br_out
);

    logic w_a_xor_b;

    assign w_a_xor_b = a ^ b;
    assign d         = w_a_xor_b ^ br_in;

    // Borrow when b exceeds a outright, or when a == b and a borrow arrives.
    assign br_out    = (~a & b) | (~w_a_xor_b & br_in);

endmodule

// File: rtl/rcs_subtractor.sv
// -----------------------------------------------------------------------------
// rcs_subtractor
//   Registered WIDTH-bit ripple-borrow subtractor:
//     {b_out, diff} = a - b - b_in   (modulo 2^(WIDTH+1))
//   plus a two's-complement overflow flag. One output register stage, so the
//   result of an operand set accepted at edge k is visible after edge k.
//   WIDTH must be >= 1.
//
//   Ports
//     clk        in   system clock, rising edge
//     rst_n      in   synchronous active-low reset
//     in_valid   in   a, b, b_in are valid this cycle; also the output-register
//                     enable, so results hold while in_valid is low
//     a          in   minuend, unsigned, WIDTH bits
//     b          in   subtrahend, unsigned, WIDTH bits
//     b_in       in   borrow-in, weight 1 at the LSB
//     diff       out  registered difference, WIDTH bits
//     b_out      out  registered borrow-out of the MSB cell
//     ovf        out  registered signed-overflow flag
//     out_valid  out  diff/b_out/ovf carry a new result this cycle
// -----------------------------------------------------------------------------
module rcs_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             ovf,
    output logic             out_valid
);

    logic [WIDTH:0]   w_br;
    logic [WIDTH-1:0] w_diff;
    logic             w_ovf;

    logic [WIDTH-1:0] r_diff;
    logic             r_b_out;
    logic             r_ovf;
    logic             r_out_valid;

    assign w_br[0] = b_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_subtractor u_fs (
            .a      (a[i]),
            .b      (b[i]),
            .br_in  (w_br[i]),
            .d      (w_diff[i]),
            .br_out (w_br[i+1])
        );
    end

    // Overflow is only possible when the operand signs differ; it shows up as
    // the result sign flipping away from the minuend sign.
    assign w_ovf = (a[WIDTH-1] ^ b[WIDTH-1]) & (w_diff[WIDTH-1] ^ a[WIDTH-1]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_diff      <= '0;
            r_b_out     <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_diff  <= w_diff;
                r_b_out <= w_br[WIDTH];
                r_ovf   <= w_ovf;
            end
        end
    end

    assign diff      = r_diff;
    assign b_out     = r_b_out;
    assign ovf       = r_ovf;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_rcs_subtractor.sv
// -----------------------------------------------------------------------------
// tb_rcs_subtractor
//   Drives an 8-bit and a 1-bit rcs_subtractor side by side. A reference model
//   computes a - b - b_in with plain integer arithmetic and keeps the expected
//   registered outputs; every cycle all outputs of both instances are checked.
// -----------------------------------------------------------------------------
module tb_rcs_subtractor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       b_in;
    logic [7:0] a8, b8;
    logic [0:0] a1, b1;

    logic [7:0] diff8;
    logic       b_out8, ovf8, out_valid8;
    logic [0:0] diff1;
    logic       b_out1, ovf1, out_valid1;

    int n_chk = 0;
    int n_err = 0;

    // expected registered state
    int e_valid;
    int e_d8, e_bo8, e_ov8;
    int e_d1, e_bo1, e_ov1;

    always #5 clk = ~clk;

    rcs_subtractor #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a8),
        .b         (b8),
        .b_in      (b_in),
        .diff      (diff8),
        .b_out     (b_out8),
        .ovf       (ovf8),
        .out_valid (out_valid8)
    );

    rcs_subtractor #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a1),
        .b         (b1),
        .b_in      (b_in),
        .diff      (diff1),
        .b_out     (b_out1),
        .ovf       (ovf1),
        .out_valid (out_valid1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Unsigned subtraction as an integer, then read borrow from the sign and
    // the difference from the low w bits.
    function automatic void ref_sub(input int w, input int av, input int bv, input int bi,
                                    output int d, output int bo, output int ov);
        int r;
        int msb_a, msb_b, msb_d;
        r     = av - bv - bi;
        bo    = (r < 0) ? 1 : 0;
        d     = r & ((1 << w) - 1);
        msb_a = (av >> (w - 1)) & 1;
        msb_b = (bv >> (w - 1)) & 1;
        msb_d = (d  >> (w - 1)) & 1;
        ov    = (msb_a != msb_b && msb_d != msb_a) ? 1 : 0;
    endfunction

    task automatic step();
        int d8, bo8, ov8, d1, bo1, ov1;
        int rst_now, v_now;
        ref_sub(8, int'(a8), int'(b8), int'(b_in), d8, bo8, ov8);
        ref_sub(1, int'(a1), int'(b1), int'(b_in), d1, bo1, ov1);
        rst_now = (rst_n == 1'b0) ? 1 : 0;
        v_now   = (in_valid == 1'b1) ? 1 : 0;
        @(posedge clk);
        #1;
        if (rst_now != 0) begin
            e_valid = 0;
            e_d8 = 0; e_bo8 = 0; e_ov8 = 0;
            e_d1 = 0; e_bo1 = 0; e_ov1 = 0;
        end else begin
            e_valid = v_now;
            if (v_now != 0) begin
                e_d8 = d8; e_bo8 = bo8; e_ov8 = ov8;
                e_d1 = d1; e_bo1 = bo1; e_ov1 = ov1;
            end
        end
        chk("valid8", 32'(out_valid8), 32'(e_valid));
        chk("diff8",  32'(diff8),      32'(e_d8));
        chk("bout8",  32'(b_out8),     32'(e_bo8));
        chk("ovf8",   32'(ovf8),       32'(e_ov8));
        chk("valid1", 32'(out_valid1), 32'(e_valid));
        chk("diff1",  32'(diff1),      32'(e_d1));
        chk("bout1",  32'(b_out1),     32'(e_bo1));
        chk("ovf1",   32'(ovf1),       32'(e_ov1));
    endtask

    task automatic apply(input logic [7:0] av, input logic [7:0] bv, input logic bi, input logic v);
        a8       = av;
        b8       = bv;
        a1       = av[0];
        b1       = bv[0];
        b_in     = bi;
        in_valid = v;
        step();
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bi;
        logic [7:0] d;
        logic       bo;
        logic       ov;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{8'h02, 8'h01, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[1] = '{8'h07, 8'h04, 1'b1, 8'h02, 1'b0, 1'b0};
        vecs[2] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
        vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[4] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[5] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[6] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};

        // reset held with valid operands present
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            apply(8'h05, 8'h01, 1'b0, 1'b1);
            chk("rst_diff",  32'(diff8),      32'h0);
            chk("rst_valid", 32'(out_valid8), 32'h0);
        end
        rst_n = 1'b1;

        // directed vectors, back to back
        for (int i = 0; i < 7; i++) begin
            apply(vecs[i].a, vecs[i].b, vecs[i].bi, 1'b1);
            chk("dir_diff",  32'(diff8),      32'(vecs[i].d));
            chk("dir_bout",  32'(b_out8),     32'(vecs[i].bo));
            chk("dir_ovf",   32'(ovf8),       32'(vecs[i].ov));
            chk("dir_valid", 32'(out_valid8), 32'h1);
        end

        // idle: valid drops, last result held
        apply(8'h11, 8'h22, 1'b0, 1'b0);
        chk("hold_valid", 32'(out_valid8), 32'h0);
        chk("hold_diff",  32'(diff8),      32'h80);
        chk("hold_bout",  32'(b_out8),     32'h1);
        apply(8'h33, 8'h01, 1'b1, 1'b0);
        chk("hold_diff2", 32'(diff8),      32'h80);

        // randomized with occasional reset pulses
        for (int i = 0; i < 1000; i++) begin
            rst_n = ($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1;
            apply(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
